// File: rtl/keypad_entry_display.sv
`default_nettype none
// ============================================================================
// Module   : keypad_entry_display
// Purpose  : 4-digit calculator-style key entry buffer driving a multiplexed
//            common-cathode 7-segment display (leading positions blanked).
//            Optional macro KEYPAD_ENTRY_DP_OVF_EN lights the leftmost
//            decimal point while the overflow flag is set.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_entry_display #(
   parameter int REFRESH_DIV = 50000,
   parameter int CNT_W       = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] key_code,
   input  logic       key_valid,
   output logic [7:0] seg,
   output logic [3:0] dig_sel,
   output logic [2:0] entry_count,
   output logic       overflow
);

   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(REFRESH_DIV - 1);
   localparam logic [3:0]       c_key_clr  = 4'hE;
   localparam logic [3:0]       c_key_bsp  = 4'hF;

   logic [3:0][3:0]  d_q, d_d;
   logic [2:0]       count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             key_valid_q, key_valid_d;
   logic             arm_q, arm_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [3:0]       dig_sel_q, dig_sel_d;
   logic [7:0]       seg_q, seg_d;
   logic             accept;
   logic [3:0]       cur_digit;

   // A press already in progress when reset releases must not count, so key
   // acceptance stays disarmed until key_valid has been seen low once.
   assign accept = key_valid & ~key_valid_q & arm_q;
   assign cur_digit = d_q[idx_q];

   always_comb begin
      d_d         = d_q;
      count_d     = count_q;
      ovf_d       = ovf_q;
      key_valid_d = key_valid;
      arm_d       = arm_q | ~key_valid;
      cnt_d       = cnt_q;
      idx_d       = idx_q;

      if (accept) begin
         if (key_code == c_key_clr) begin
            d_d     = '0;
            count_d = 3'd0;
            ovf_d   = 1'b0;
         end else if (key_code == c_key_bsp) begin
            d_d     = {4'h0, d_q[3], d_q[2], d_q[1]};
            count_d = (count_q == 3'd0) ? 3'd0 : count_q - 3'd1;
         end else begin
            d_d = {d_q[2], d_q[1], d_q[0], key_code};
            if (count_q == 3'd4) begin
               ovf_d = 1'b1;
            end else begin
               count_d = count_q + 3'd1;
            end
         end
      end

      if (cnt_q == c_cnt_last) begin
         cnt_d = '0;
         idx_d = idx_q + 2'd1;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end

      dig_sel_d = ~(4'b0001 << idx_q);

      seg_d = 8'h00;
      if ({1'b0, idx_q} < count_q) begin
         case (cur_digit)
            4'h0:    seg_d = 8'h3F;
            4'h1:    seg_d = 8'h06;
            4'h2:    seg_d = 8'h5B;
            4'h3:    seg_d = 8'h4F;
            4'h4:    seg_d = 8'h66;
            4'h5:    seg_d = 8'h6D;
            4'h6:    seg_d = 8'h7D;
            4'h7:    seg_d = 8'h07;
            4'h8:    seg_d = 8'h7F;
            4'h9:    seg_d = 8'h6F;
            4'hA:    seg_d = 8'h77;
            4'hB:    seg_d = 8'h7C;
            4'hC:    seg_d = 8'h39;
            4'hD:    seg_d = 8'h5E;
            default: seg_d = 8'h00;
         endcase
      end
`ifdef KEYPAD_ENTRY_DP_OVF_EN
      seg_d[7] = ovf_q && (idx_q == 2'd3);
`else
      seg_d[7] = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         d_q         <= '0;
         count_q     <= 3'd0;
         ovf_q       <= 1'b0;
         key_valid_q <= 1'b0;
         arm_q       <= 1'b0;
         cnt_q       <= '0;
         idx_q       <= 2'd0;
         dig_sel_q   <= 4'b1110;
         seg_q       <= 8'h00;
      end else begin
         d_q         <= d_d;
         count_q     <= count_d;
         ovf_q       <= ovf_d;
         key_valid_q <= key_valid_d;
         arm_q       <= arm_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         dig_sel_q   <= dig_sel_d;
         seg_q       <= seg_d;
      end
   end

   assign seg         = seg_q;
   assign dig_sel     = dig_sel_q;
   assign entry_count = count_q;
   assign overflow    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_entry_display
// Purpose  : Directed self-checking bench for keypad_entry_display
//            (REFRESH_DIV=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_entry_display;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] key_code = 4'h0;
   logic       key_valid = 1'b0;
   logic [7:0] seg;
   logic [3:0] dig_sel;
   logic [2:0] entry_count;
   logic       overflow;

   int n_checks = 0;
   int n_pass   = 0;

`ifdef KEYPAD_ENTRY_DP_OVF_EN
   localparam logic [7:0] c_dp = 8'h80;
`else
   localparam logic [7:0] c_dp = 8'h00;
`endif

   keypad_entry_display #(.REFRESH_DIV(4), .CNT_W(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .key_code   (key_code),
      .key_valid  (key_valid),
      .seg        (seg),
      .dig_sel    (dig_sel),
      .entry_count(entry_count),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic press(input logic [3:0] code, input int hold);
      @(negedge clk);
      key_code  = code;
      key_valid = 1'b1;
      repeat (hold) @(negedge clk);
      key_valid = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   // Wait (bounded) for a digit position to be enabled, then check its segments.
   task automatic check_digit(input int pos, input logic [7:0] exp);
      logic [3:0] want;
      int i;
      want = ~(4'b0001 << pos);
      i = 0;
      @(negedge clk);
      while (dig_sel !== want && i < 64) begin
         @(negedge clk);
         i++;
      end
      if (dig_sel !== want) check($sformatf("dig%0d_timeout", pos), {28'h0, dig_sel}, {28'h0, want});
      else check($sformatf("seg_dig%0d", pos), {24'h0, seg}, {24'h0, exp});
   endtask

   initial begin
      logic [3:0] exp_sel;
      int i;

      // Reset state
      #12;
      check("rst_dig_sel", {28'h0, dig_sel}, 32'hE);
      check("rst_seg", {24'h0, seg}, 32'h0);
      check("rst_count", {29'h0, entry_count}, 32'h0);
      check("rst_ovf", {31'h0, overflow}, 32'h0);

      // Scan sequence after release, blank display
      @(negedge clk);
      rst = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         exp_sel = ~(4'b0001 << ((k - 1) / 4));
         check($sformatf("scan%0d_sel", k), {28'h0, dig_sel}, {28'h0, exp_sel});
         check($sformatf("scan%0d_seg", k), {24'h0, seg}, 32'h0);
      end

      // Long hold produces a single acceptance
      press(4'h5, 10);
      check("hold_count", {29'h0, entry_count}, 32'd1);
      check_digit(0, 8'h6D);
      check_digit(1, 8'h00);
      check_digit(2, 8'h00);
      check_digit(3, 8'h00);

      // Fill and overflow: buffer becomes 2,3,4,7
      press(4'h1, 1);
      press(4'h2, 2);
      press(4'h3, 1);
      check("ovf_before", {31'h0, overflow}, 32'h0);
      press(4'h4, 1);
      press(4'h7, 3);
      check("full_count", {29'h0, entry_count}, 32'd4);
      check("full_ovf", {31'h0, overflow}, 32'h1);
      check_digit(3, 8'h5B | c_dp);
      check_digit(2, 8'h4F);
      check_digit(1, 8'h66);
      check_digit(0, 8'h07);

      // Two backspaces: _,_,2,3
      press(4'hF, 1);
      press(4'hF, 1);
      check("bsp_count", {29'h0, entry_count}, 32'd2);
      check("bsp_ovf", {31'h0, overflow}, 32'h1);
      check_digit(1, 8'h5B);
      check_digit(0, 8'h4F);
      check_digit(2, 8'h00);
      check_digit(3, c_dp);

      // Clear
      press(4'hE, 1);
      check("clr_count", {29'h0, entry_count}, 32'd0);
      check("clr_ovf", {31'h0, overflow}, 32'h0);
      for (int p = 0; p < 4; p++) check_digit(p, 8'h00);

      // Backspace at zero, then A
      press(4'hF, 1);
      check("bsp0_count", {29'h0, entry_count}, 32'd0);
      press(4'hA, 1);
      check("a_count", {29'h0, entry_count}, 32'd1);
      check_digit(0, 8'h77);
      check_digit(1, 8'h00);

      // Reset mid-scan at index 2 with key held
      @(negedge clk);
      key_code  = 4'h3;
      key_valid = 1'b1;
      i = 0;
      @(negedge clk);
      while (dig_sel !== 4'b1011 && i < 64) begin
         @(negedge clk);
         i++;
      end
      check("mid_sel", {28'h0, dig_sel}, 32'hB);
      check("mid_count", {29'h0, entry_count}, 32'd2);
      #1 rst = 1'b0;
      #1;
      check("arst_sel", {28'h0, dig_sel}, 32'hE);
      check("arst_seg", {24'h0, seg}, 32'h0);
      check("arst_count", {29'h0, entry_count}, 32'd0);
      check("arst_ovf", {31'h0, overflow}, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      repeat (8) @(negedge clk);
      check("held_no_accept", {29'h0, entry_count}, 32'd0);
      key_valid = 1'b0;
      @(negedge clk);
      key_code  = 4'h9;
      key_valid = 1'b1;
      @(negedge clk);
      check("repress_count", {29'h0, entry_count}, 32'd1);
      key_valid = 1'b0;
      check_digit(0, 8'h6F);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/keypad_entry_display.md
Name: keypad_entry_display

Overview:
- Downstream consumer of the 4x4 keypad scanner's decoded 4-bit key code.
- Collects keypresses into a 4-digit entry buffer, calculator style: new digits shift in from the right.
- Drives a time-multiplexed 4-digit common-cathode 7-segment display, with leading-position blanking.
- Codes 0xE (`*`) and 0xF (`#`) are commands: clear and backspace.

Parameters:
- REFRESH_DIV, 50000: clk cycles each digit is displayed before the scan advances. Legal range is 2 or more.
- CNT_W, 16: width of the refresh counter. Must satisfy 2^CNT_W >= REFRESH_DIV.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- key_code  in  4  decoded key value from the scanner, 0x0–0xF
- key_valid  in  1  high while key_code is a valid pressed key; may stay high for many cycles
- seg  out  8  segment drive, active-high, bit0=a … bit6=g, bit7=dp
- dig_sel  out  4  digit enable, active-low one-hot; bit0 = rightmost digit
- entry_count  out  3  number of digits entered, 0–4
- overflow  out  1  sticky flag: a digit was pushed out of the buffer

Behaviour:
- Reset (asynchronous, rst=0) clears everything immediately, including mid-scan or mid-keypress:
  - d0–d3 = 0, entry_count = 0, overflow = 0
  - scan index = 0, refresh counter = 0, key_valid_d = 0
  - dig_sel = 4'b1110, seg = 8'h00
- Key acceptance:
  - A key is accepted only on a rising edge of key_valid, i.e. key_valid=1 and registered key_valid_d=0.
  - Holding key_valid high produces exactly one acceptance.
  - key_code is sampled on the same clk edge; buffer state updates on that edge, so latency is 1 cycle.
- Digit codes 0x0–0xD:
  - Shift left: d3<=d2, d2<=d1, d1<=d0, d0<=key_code.
  - entry_count increments and saturates at 4.
  - If entry_count was already 4, the old d3 is discarded and overflow<=1.
- Code 0xE (clear): d0–d3<=0, entry_count<=0, overflow<=0.
- Code 0xF (backspace):
  - Shift right: d0<=d1, d1<=d2, d2<=d3, d3<=0.
  - entry_count decrements and saturates at 0.
  - overflow is unchanged.
  - Backspace at count 0 is a no-op apart from the shift of zeros.
- Refresh scan:
  - The counter runs 0..REFRESH_DIV-1 continuously and wraps.
  - On the terminal count, the 2-bit scan index increments and wraps 3 -> 0.
  - dig_sel is a registered output equal to ~(1<<index). It updates one cycle after the index changes; seg updates in the same cycle.
- Segment output (registered, computed from the selected digit d[index]):
  - If index >= entry_count, seg = 8'h00 (blank).
  - Otherwise seg = decode(d[index]) with this map:
    - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
    - 8=7F, 9=6F, A=77, B=7C, C=39, D=5E
  - Codes E and F never reach the buffer.
  - seg[7]=0 unless the optional feature below is enabled.
- Simultaneous events:
  - A key acceptance and a scan advance on the same edge both take effect.
  - The seg value registered on the following edge reflects the updated buffer.
- No other state machine: the buffer is a saturating shift register and the scan is a free-running counter.

Optional Feature:
- Macro: KEYPAD_ENTRY_DP_OVF_EN
- When defined: seg[7]=1 while overflow=1 and scan index=3 (leftmost digit). This overrides blanking for that bit only.
- When undefined: seg[7] is constantly 0. The overflow port behaves identically in both builds.

Test Plan:
- All tests use REFRESH_DIV=4.
- Reset release: -> dig_sel=1110, seg=00, entry_count=0. Over the next 16 cycles, dig_sel cycles 1110, 1101, 1011, 0111 (4 cycles each) and seg stays 00.
- Hold key_valid=1 with code 0x5 for 10 cycles: -> exactly one acceptance, entry_count=1, d0=5. When dig_sel=1110, seg=6D; all other digits show 00.
- Pulse codes 1,2,3,4 then 7: -> entry_count=4, overflow=1, digits from left to right read 2,3,4,7. Digit 3 shows seg=5B (DB with KEYPAD_ENTRY_DP_OVF_EN defined).
- From buffer 2,3,4,7, press 0xF twice: -> entry_count=2, display _,_,2,3, overflow still 1. Then press 0xE: -> count=0, overflow=0, all seg=00.
- Backspace at count 0, followed by code 0xA: -> count stays 0 after backspace, then 1. Digit 0 shows seg=77.
- Assert rst low mid-scan while the index is 2 and key_valid is high: -> all outputs return to reset values immediately. After release with key_valid still high, no key is accepted until key_valid falls and rises again.
